// File: rtl/ysyx_23060075_lsu_bus.sv
// ysyx_23060075_lsu_bus: multi-cycle load/store unit between EXU and WBU.
// Accepts one op at a time, issues a single request on a req/resp bus,
// waits for the response (with optional timeout) and extends load data.
// Optional feature macro: YSYX_23060075_LSU_MISALIGN_CHECK_EN -- when defined,
// ops whose address is not size-aligned fault immediately without a bus request.
module ysyx_23060075_lsu_bus #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [2:0]        in_funct3,
    input  logic              in_r_en,
    input  logic              in_w_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [XLEN/8-1:0] req_wstrb,
    input  logic              resp_valid,
    input  logic [XLEN-1:0]   resp_rdata,
    input  logic              resp_err
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    // Counter is wide enough to hold TIMEOUT_CYC; one extra bit for the incremented compare.
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW:0] TO_VAL = TIMEOUT_CYC[CW:0];

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW:0]     cnt_inc;
    logic [OW-1:0]   cur_off;
    logic [1:0]      cur_size;
    logic            cur_uns;

    // Decoded view of the incoming op.
    logic [OW-1:0]   in_off;
    logic [1:0]      in_size;
    logic            in_uns;
    logic [NB-1:0]   in_mask;
    logic [NB-1:0]   in_strb;
    logic [XLEN-1:0] in_wshift;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_ext;
`ifdef YSYX_23060075_LSU_MISALIGN_CHECK_EN
    logic [OW-1:0]   align_mask;
    logic            misaligned;
`endif

    // Decode access size/signedness and build the aligned store data and strobes.
    always_comb begin
        in_off  = in_addr[OW-1:0];
        in_size = in_funct3[1:0];
        in_uns  = in_funct3[2];
        // 111 is undefined and D/WU do not exist on a 32-bit datapath: fall back to W.
        if (in_funct3 == 3'b111) begin
            in_size = 2'd2;
            in_uns  = 1'b0;
        end
        if (XLEN == 32 && in_size == 2'd3) in_size = 2'd2;
        unique case (in_size)
            2'd0:    in_mask = NB'(8'h01);
            2'd1:    in_mask = NB'(8'h03);
            2'd2:    in_mask = NB'(8'h0F);
            default: in_mask = NB'(8'hFF);
        endcase
        // Bytes past the end of the word fall off the top of the strobe.
        in_strb   = in_mask << in_off;
        in_wshift = in_wdata << {in_off, 3'b000};
    end

`ifdef YSYX_23060075_LSU_MISALIGN_CHECK_EN
    // Low address bits that must be zero for the decoded access size.
    always_comb begin
        align_mask = OW'((32'd1 << in_size) - 32'd1);
        misaligned = |(in_off & align_mask);
    end
`endif

    // Move the addressed bytes of the response down to bit 0 and extend them.
    always_comb begin
        ld_shift = resp_rdata >> {cur_off, 3'b000};
        unique case (cur_size)
            2'd0:    ld_ext = cur_uns ? XLEN'(ld_shift[7:0])  : XLEN'($signed(ld_shift[7:0]));
            2'd1:    ld_ext = cur_uns ? XLEN'(ld_shift[15:0]) : XLEN'($signed(ld_shift[15:0]));
            2'd2:    ld_ext = cur_uns ? XLEN'(ld_shift[31:0]) : XLEN'($signed(ld_shift[31:0]));
            default: ld_ext = ld_shift;
        endcase
        cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    end

    // Control FSM; every port output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_err   <= 1'b0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            cnt       <= '0;
            cur_off   <= '0;
            cur_size  <= '0;
            cur_uns   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready  <= 1'b0;
                        cur_off   <= in_off;
                        cur_size  <= in_size;
                        cur_uns   <= in_uns;
                        out_rdata <= '0;
                        out_err   <= 1'b0;
                        if (in_r_en && in_w_en) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                        end else if (!in_r_en && !in_w_en) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
`ifdef YSYX_23060075_LSU_MISALIGN_CHECK_EN
                        end else if (misaligned) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
`endif
                        end else begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_we    <= in_w_en;
                            req_addr  <= {in_addr[ADDR_W-1:OW], {OW{1'b0}}};
                            req_wdata <= in_w_en ? in_wshift : '0;
                            req_wstrb <= in_w_en ? in_strb : '0;
                        end
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc[CW-1:0];
                    // A response in the last allowed cycle still wins over the timeout.
                    if (resp_valid) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_err   <= resp_err;
                        out_rdata <= (resp_err || req_we) ? '0 : ld_ext;
                    end else if (TIMEOUT_CYC != 0 && cnt_inc == TO_VAL) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        out_rdata <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
